vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA controller timing logic.
- Generates pixel-clock enable, raster counters, sync/blank strobes and frame events for any VESA-style mode.
- Adds a programmable pipeline delay so that sync and blank outputs stay aligned with downstream glyph-ROM/bitgen RGB latency.
- Sits between the system clock and the glyph/bitgen path; feeds the hcount/vcount address path and the VGA DAC pins.

---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vga_delay_line.sv | 37 +++
 rtl/vga_timing_gen.sv | 175 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, bar colours and helpers.
// Imported by vga_timing_gen and vga_delay_line.
package vga_pkg;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    function automatic int vga_total(
        input int vis,
        input int fp,
        input int sync,
        input int bp
    );
        return vis + fp + sync + bp;
    endfunction

    function automatic logic [23:0] bar_colour(
        input logic [2:0] idx
    );
        logic [23:0] c;
        c = RGB_BLACK;
        unique case (idx)
            3'd0: c = RGB_WHITE;
            3'd1: c = RGB_YELLOW;
            3'd2: c = RGB_CYAN;
            3'd3: c = RGB_GREEN;
            3'd4: c = RGB_MAGENTA;
            3'd5: c = RGB_RED;
            3'd6: c = RGB_BLUE;
            3'd7: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enable-gated shift register, DEPTH stages.
// DEPTH = 0 passes d straight through.
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stage [DEPTH];

        // shift one slot per enable, clear to RESET_VAL
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++)
                    stage[i] <= RESET_VAL;
            end else if (en) begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++)
                    stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with aligned strobes.
// Optional colour-bar generator enabled by VGA_TEST_PATTERN_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CNT_W    = 10,
    parameter int CLK_DIV  = 2,
    parameter int H_VIS    = VGA_H_VIS,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_VIS    = VGA_V_VIS,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int SYNC_POL = 0,
    parameter int PIPE_DLY = 2
) (
    input  logic             clk,
    input  logic             rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_mode,
    output logic [23:0]      tp_rgb,
`endif
    output logic             hsync,
    output logic             vsync,
    output logic             vga_blank_n,
    output logic             vga_clk,
    output logic             bright,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             pix_en,
    output logic             sof,
    output logic             eol,
    output logic [7:0]       frame_cnt
);

    localparam int H_TOTAL =
        vga_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL =
        vga_total(V_VIS, V_FP, V_SYNC, V_BP);
    localparam int DIV_W =
        (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (H_TOTAL > (1 << CNT_W) ||
        V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
        $error("vga_timing_gen: totals exceed CNT_W");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY out of 0..7");
    end

    localparam logic [DIV_W-1:0] DIV_LAST =
        DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF =
        DIV_W'(CLK_DIV / 2);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_EOL  = CNT_W'(H_VIS - 1);
    localparam logic [CNT_W-1:0] H_VEND = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VEND = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END =
        CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END =
        CNT_W'(V_VIS + V_FP + V_SYNC);

    localparam logic POL = (SYNC_POL != 0);

    logic [DIV_W-1:0] div;
    logic             h_last;
    logic             v_last;
    logic             h_act;
    logic             v_act;
    logic             vis;
    logic             h_act_d;
    logic             v_act_d;
    logic             vis_d;

    // pixel-rate divider, one pix_en per CLK_DIV clocks
    always_ff @(posedge clk) begin
        if (rst)
            div <= '0;
        else if (div == DIV_LAST)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    assign pix_en = (div == DIV_LAST);

    if (CLK_DIV == 1) begin : g_clk_sim
        assign vga_clk = 1'b0;
    end else begin : g_clk_div
        assign vga_clk = (div >= DIV_HALF);
    end

    assign h_last = (hcount == H_LAST);
    assign v_last = (vcount == V_LAST);

    // raster position and frame count, advanced per pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount    <= '0;
            vcount    <= '0;
            frame_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                hcount <= '0;
                if (v_last) begin
                    vcount    <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    vcount <= vcount + 1'b1;
                end
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    assign sof = pix_en & h_last & v_last;
    assign eol = pix_en & (hcount == H_EOL) &
                 (vcount < V_VEND);

    assign h_act = (hcount >= HS_BEG) && (hcount < HS_END);
    assign v_act = (vcount >= VS_BEG) && (vcount < VS_END);
    assign vis   = (hcount < H_VEND) && (vcount < V_VEND);

    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL (3'b000)
    ) u_strobe_dly (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .d   ({h_act, v_act, vis}),
        .q   ({h_act_d, v_act_d, vis_d})
    );

    assign hsync       = h_act_d ? POL : ~POL;
    assign vsync       = v_act_d ? POL : ~POL;
    assign vga_blank_n = vis_d;
    assign bright      = vis_d;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_VIS / 8 > 0) ? H_VIS / 8 : 1;

    logic [CNT_W-1:0] bar_idx;
    logic [23:0]      tp_raw;

    assign bar_idx = hcount / CNT_W'(BAR_W);
    assign tp_raw  = (vis && test_mode) ?
                     bar_colour(bar_idx[2:0]) : 24'h0;

    vga_delay_line #(
        .WIDTH     (24),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL (24'h0)
    ) u_tp_dly (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .d   (tp_raw),
        .q   (tp_rgb)
    );
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of two small-mode instances.
// A: CLK_DIV 2, no delay, active-low; B: CLK_DIV 4, delay 2, active-high.
module tb_vga_timing_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 1;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = 14, VT = 8;
    localparam int FRAME_A = 224;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic       hs_a, vs_a, bl_a, vc_a, br_a;
    logic       pe_a, sof_a, eol_a;
    logic [9:0] hc_a, vcnt_a;
    logic [7:0] fc_a;

    logic       hs_b, vs_b, bl_b, vc_b, br_b;
    logic       pe_b, sof_b, eol_b;
    logic [9:0] hc_b, vcnt_b;
    logic [7:0] fc_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CNT_W(10), .CLK_DIV(2),
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0), .PIPE_DLY(0)
    ) u_a (
        .clk(clk), .rst(rst_a),
        .hsync(hs_a), .vsync(vs_a),
        .vga_blank_n(bl_a), .vga_clk(vc_a),
        .bright(br_a), .hcount(hc_a), .vcount(vcnt_a),
        .pix_en(pe_a), .sof(sof_a), .eol(eol_a),
        .frame_cnt(fc_a)
    );

    vga_timing_gen #(
        .CNT_W(10), .CLK_DIV(4),
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1), .PIPE_DLY(2)
    ) u_b (
        .clk(clk), .rst(rst_b),
        .hsync(hs_b), .vsync(vs_b),
        .vga_blank_n(bl_b), .vga_clk(vc_b),
        .bright(br_b), .hcount(hc_b), .vcount(vcnt_b),
        .pix_en(pe_b), .sof(sof_b), .eol(eol_b),
        .frame_cnt(fc_b)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic bit h_on(input int h);
        return h >= HV + HF && h < HV + HF + HS;
    endfunction

    function automatic bit v_on(input int v);
        return v >= VV + VF && v < VV + VF + VS;
    endfunction

    function automatic bit vis_on(input int h, input int v);
        return h < HV && v < VV;
    endfunction

    // c = clocks since reset release; sampled at negedge
    task automatic chk_a(input int c, input bit full);
        int t, h, v;
        bit pe;
        t  = c / 2;
        h  = t % HT;
        v  = (t / HT) % VT;
        pe = (c % 2) == 1;
        if (full) begin
            check("a_hcount", hc_a, h);
            check("a_vcount", vcnt_a, v);
            check("a_pix_en", pe_a, pe);
            check("a_vga_clk", vc_a, pe);
            check("a_hsync", hs_a, !h_on(h));
            check("a_vsync", vs_a, !v_on(v));
            check("a_blank_n", bl_a, vis_on(h, v));
            check("a_bright", br_a, vis_on(h, v));
            check("a_eol", eol_a, pe && h == HV - 1 && v < VV);
        end
        check("a_sof", sof_a, pe && h == HT - 1 && v == VT - 1);
        check("a_frame", fc_a, (c / FRAME_A) % 256);
    endtask

    task automatic chk_b(input int c);
        int t, h, v, hd, vd;
        bit pe, hx, vx, bx;
        t  = c / 4;
        h  = t % HT;
        v  = (t / HT) % VT;
        pe = (c % 4) == 3;
        hx = 1'b0;
        vx = 1'b0;
        bx = 1'b0;
        if (t >= 2) begin
            hd = (t - 2) % HT;
            vd = ((t - 2) / HT) % VT;
            hx = h_on(hd);
            vx = v_on(vd);
            bx = vis_on(hd, vd);
        end
        check("b_hcount", hc_b, h);
        check("b_vcount", vcnt_b, v);
        check("b_pix_en", pe_b, pe);
        check("b_vga_clk", vc_b, (c % 4) >= 2);
        check("b_hsync", hs_b, hx);
        check("b_vsync", vs_b, vx);
        check("b_blank_n", bl_b, bx);
        check("b_bright", br_b, bx);
        check("b_sof", sof_b, pe && h == HT - 1 && v == VT - 1);
        check("b_eol", eol_b, pe && h == HV - 1 && v < VV);
        check("b_frame", fc_b, (c / (FRAME_A * 2)) % 256);
    endtask

    initial begin
        int guard;
        repeat (4) @(posedge clk);
        @(negedge clk);

        check("rst_a_hcount", hc_a, 0);
        check("rst_a_vcount", vcnt_a, 0);
        check("rst_a_hsync", hs_a, 1);
        check("rst_a_vsync", vs_a, 1);
        check("rst_a_pix_en", pe_a, 0);
        check("rst_a_sof", sof_a, 0);
        check("rst_a_eol", eol_a, 0);
        check("rst_a_frame", fc_a, 0);
        check("rst_b_hsync", hs_b, 0);
        check("rst_b_vsync", vs_b, 0);
        check("rst_b_blank_n", bl_b, 0);
        check("rst_b_bright", br_b, 0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            chk_a(c, 1'b1);
            chk_b(c);
            @(negedge clk);
        end

        guard = 0;
        while (!(hc_a == 10'd5 && vcnt_a == 10'd2) &&
               guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("mid_frame_wait", guard < 300, 1);

        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_hcount", hc_a, 0);
        check("mid_rst_vcount", vcnt_a, 0);
        check("mid_rst_hsync", hs_a, 1);
        check("mid_rst_vsync", vs_a, 1);
        check("mid_rst_frame", fc_a, 0);
        check("mid_rst_sof", sof_a, 0);
        check("mid_rst_pix_en", pe_a, 0);

        rst_a = 1'b0;
        for (int c = 0; c < 256 * FRAME_A + 4; c++) begin
            chk_a(c, c < 2 * FRAME_A + 20);
            if (c == 255 * FRAME_A + FRAME_A - 1) begin
                check("wrap_pre_frame", fc_a, 255);
                check("wrap_pre_sof", sof_a, 1);
            end
            if (c == 256 * FRAME_A)
                check("wrap_post_frame", fc_a, 0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
